// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter for the icache and dcache; data side has fixed priority.
// Define ARB_STARVE_GUARD_EN to force an instruction grant after STARVE_LIMIT data grants.
module cache_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t state, next_state;
    logic   dreq;
    logic   force_i;

    assign dreq = dREN | dWEN;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starvecnt;

    // Counts data completions that overtook a pending instruction fetch.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starvecnt <= '0;
        end else if (state == IGRANT && iREN && ramstate == RAM_ACCESS) begin
            starvecnt <= '0;
        end else if (state == IDLE && !iREN) begin
            starvecnt <= '0;
        end else if (state == DGRANT && dreq && ramstate == RAM_ACCESS && iREN
                     && starvecnt != LIMIT) begin
            starvecnt <= starvecnt + 1'b1;
        end
    end

    assign force_i = iREN && (starvecnt == LIMIT);
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign force_i = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant owner's address/data pass straight through; a dropped enable ends the grant.
    always_comb begin
        next_state = state;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        case (state)
            IDLE: begin
                if (force_i) begin
                    next_state = IGRANT;
                end else if (dreq) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end
            DGRANT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    next_state = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    dwait      = 1'b0;
                    dload      = ramload;
                    next_state = IDLE;
                end
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed, table-driven bench for cache_mem_arbiter; honours ARB_STARVE_GUARD_EN.
module tb_cache_mem_arbiter;

    localparam logic [1:0] FREE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        i_ren;
        logic [31:0] i_addr;
        logic        d_ren;
        logic        d_wen;
        logic [31:0] d_addr;
        logic [31:0] d_store;
        logic [31:0] r_load;
        logic [1:0]  r_state;
        logic        e_iwait;
        logic [31:0] e_iload;
        logic        e_dwait;
        logic [31:0] e_dload;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
    } vec_t;

    vec_t vecs[22];

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(
        input logic i_ren, input logic [31:0] i_addr, input logic d_ren, input logic d_wen,
        input logic [31:0] d_addr, input logic [31:0] d_store, input logic [31:0] r_load,
        input logic [1:0] r_state, input logic e_iwait, input logic [31:0] e_iload,
        input logic e_dwait, input logic [31:0] e_dload, input logic e_ren, input logic e_wen,
        input logic [31:0] e_addr, input logic [31:0] e_store);
        vec_t v;
        v.i_ren = i_ren;   v.i_addr = i_addr;   v.d_ren = d_ren;     v.d_wen = d_wen;
        v.d_addr = d_addr; v.d_store = d_store; v.r_load = r_load;   v.r_state = r_state;
        v.e_iwait = e_iwait; v.e_iload = e_iload; v.e_dwait = e_dwait; v.e_dload = e_dload;
        v.e_ren = e_ren;   v.e_wen = e_wen;     v.e_addr = e_addr;   v.e_store = e_store;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        iREN     = v.i_ren;
        iaddr    = v.i_addr;
        dREN     = v.d_ren;
        dWEN     = v.d_wen;
        daddr    = v.d_addr;
        dstore   = v.d_store;
        ramload  = v.r_load;
        ramstate = v.r_state;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, " iwait"}, {31'd0, iwait}, 32'd1);
        checkOutput({name, " dwait"}, {31'd0, dwait}, 32'd1);
        checkOutput({name, " ramREN"}, {31'd0, ramREN}, 32'd0);
        checkOutput({name, " ramWEN"}, {31'd0, ramWEN}, 32'd0);
        checkOutput({name, " ramaddr"}, ramaddr, 32'd0);
        checkOutput({name, " ramstore"}, ramstore, 32'd0);
        checkOutput({name, " iload"}, iload, 32'd0);
        checkOutput({name, " dload"}, dload, 32'd0);
    endtask

    task automatic checkVec(input int idx, input vec_t v);
        string n;
        n = $sformatf("vec%0d", idx);
        checkOutput({n, " iwait"}, {31'd0, iwait}, {31'd0, v.e_iwait});
        checkOutput({n, " iload"}, iload, v.e_iload);
        checkOutput({n, " dwait"}, {31'd0, dwait}, {31'd0, v.e_dwait});
        checkOutput({n, " dload"}, dload, v.e_dload);
        checkOutput({n, " ramREN"}, {31'd0, ramREN}, {31'd0, v.e_ren});
        checkOutput({n, " ramWEN"}, {31'd0, ramWEN}, {31'd0, v.e_wen});
        checkOutput({n, " ramaddr"}, ramaddr, v.e_addr);
        checkOutput({n, " ramstore"}, ramstore, v.e_store);
    endtask

    initial begin
        int expCls[12];
        int cls;

        // idle / IGRANT fetch
        vecs[0]  = mk(1, 32'h40, 0, 0, 0, 0, 0, FREE,            1, 0, 1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 32'h40, 0, 0, 0, 0, 32'h2108_0001, ACC, 0, 32'h2108_0001, 1, 0, 1, 0, 32'h40, 0);
        vecs[2]  = mk(0, 32'h40, 0, 0, 0, 0, 0, FREE,            1, 0, 1, 0, 0, 0, 0, 0);
        // simultaneous iREN + dWEN, RAM BUSY twice then ACCESS, then turnaround and IGRANT
        vecs[3]  = mk(1, 32'h40, 0, 1, 32'h100, 32'hDEAD_BEEF, 0, FREE, 1, 0, 1, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 32'h40, 0, 1, 32'h100, 32'hDEAD_BEEF, 0, BUSY, 1, 0, 1, 0, 0, 1, 32'h100, 32'hDEAD_BEEF);
        vecs[5]  = mk(1, 32'h40, 0, 1, 32'h100, 32'hDEAD_BEEF, 0, BUSY, 1, 0, 1, 0, 0, 1, 32'h100, 32'hDEAD_BEEF);
        vecs[6]  = mk(1, 32'h40, 0, 1, 32'h100, 32'hDEAD_BEEF, 0, ACC,  1, 0, 0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF);
        vecs[7]  = mk(1, 32'h40, 0, 0, 0, 0, 0, FREE,            1, 0, 1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(1, 32'h40, 0, 0, 0, 0, 32'hCAFE_0001, ACC, 0, 32'hCAFE_0001, 1, 0, 1, 0, 32'h40, 0);
        // data read with three ERROR cycles
        vecs[9]  = mk(0, 32'h40, 1, 0, 32'h200, 0, 0, FREE,     1, 0, 1, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 32'h40, 1, 0, 32'h200, 0, 32'h55, ERR, 1, 0, 1, 0, 1, 0, 32'h200, 0);
        vecs[11] = mk(0, 32'h40, 1, 0, 32'h200, 0, 32'h55, ERR, 1, 0, 1, 0, 1, 0, 32'h200, 0);
        vecs[12] = mk(0, 32'h40, 1, 0, 32'h200, 0, 32'h55, ERR, 1, 0, 1, 0, 1, 0, 32'h200, 0);
        vecs[13] = mk(0, 32'h40, 1, 0, 32'h200, 0, 32'hA5A5_0003, ACC, 1, 0, 0, 32'hA5A5_0003, 1, 0, 32'h200, 0);
        // iREN withdrawn in IGRANT
        vecs[14] = mk(1, 32'h80, 0, 0, 0, 0, 0, FREE,     1, 0, 1, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, 32'h80, 0, 0, 0, 0, 32'h99, BUSY, 1, 0, 1, 0, 1, 0, 32'h80, 0);
        vecs[16] = mk(0, 32'h80, 0, 0, 0, 0, 32'h99, ACC,  1, 0, 1, 0, 0, 0, 32'h80, 0);
        vecs[17] = mk(0, 32'h80, 0, 0, 0, 0, 32'h99, ACC,  1, 0, 1, 0, 0, 0, 0, 0);
        // dREN withdrawn in DGRANT
        vecs[18] = mk(0, 0, 1, 0, 32'h300, 0, 0, FREE,     1, 0, 1, 0, 0, 0, 0, 0);
        vecs[19] = mk(0, 0, 1, 0, 32'h300, 0, 0, BUSY,     1, 0, 1, 0, 1, 0, 32'h300, 0);
        vecs[20] = mk(0, 0, 0, 0, 32'h300, 0, 32'h66, ACC, 1, 0, 1, 0, 0, 0, 32'h300, 0);
        vecs[21] = mk(0, 0, 0, 0, 32'h300, 0, 32'h66, ACC, 1, 0, 1, 0, 0, 0, 0, 0);

        // reset with both requests asserted
        nRST = 1'b0;
        applyStimulus(mk(1, 32'h44, 1, 0, 32'h10, 0, 32'h77, ACC, 1, 0, 1, 0, 0, 0, 0, 0));
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            #1;
            checkIdle($sformatf("reset%0d", c));
        end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        checkIdle("post-reset idle");
        @(negedge CLK);
        #1;
        checkOutput("post-reset dgrant ramREN", {31'd0, ramREN}, 32'd1);
        checkOutput("post-reset dgrant ramaddr", ramaddr, 32'h10);
        checkOutput("post-reset dgrant dwait", {31'd0, dwait}, 32'd0);
        checkOutput("post-reset dgrant dload", dload, 32'h77);
        checkOutput("post-reset dgrant iwait", {31'd0, iwait}, 32'd1);
        @(negedge CLK);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, FREE, 1, 0, 1, 0, 0, 0, 0, 0));
        #1;
        checkIdle("turnaround idle");

        for (int i = 0; i < 22; i++) begin
            @(negedge CLK);
            applyStimulus(vecs[i]);
            #1;
            checkVec(i, vecs[i]);
        end

        // continuous dREN + iREN with instant ACCESS: grant order
        @(negedge CLK);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, FREE, 1, 0, 1, 0, 0, 0, 0, 0));
        for (int c = 0; c < 12; c++) expCls[c] = (c % 2 == 1) ? 1 : 0;
`ifdef ARB_STARVE_GUARD_EN
        expCls[9] = 2;
`endif
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            applyStimulus(mk(1, 32'h44, 1, 0, 32'h400, 0, 32'h1000 + c, ACC, 1, 0, 1, 0, 0, 0, 0, 0));
            #1;
            cls = (ramREN && ramaddr == 32'h44) ? 2 : (ramREN && ramaddr == 32'h400) ? 1 : 0;
            checkOutput($sformatf("starve cycle%0d grant", c), cls, expCls[c]);
            checkOutput($sformatf("starve cycle%0d iwait", c), {31'd0, iwait}, (expCls[c] == 2) ? 32'd0 : 32'd1);
            checkOutput($sformatf("starve cycle%0d dwait", c), {31'd0, dwait}, (expCls[c] == 1) ? 32'd0 : 32'd1);
        end

        // reset asserted mid-grant drops RAM enables immediately
        @(negedge CLK);
        applyStimulus(mk(0, 0, 1, 0, 32'h500, 0, 0, BUSY, 1, 0, 1, 0, 0, 0, 0, 0));
        #1;
        checkIdle("pre-abort idle");
        @(negedge CLK);
        #1;
        checkOutput("abort dgrant ramREN", {31'd0, ramREN}, 32'd1);
        checkOutput("abort dgrant ramaddr", ramaddr, 32'h500);
        #1;
        nRST = 1'b0;
        #1;
        checkIdle("async abort");
        @(negedge CLK);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, FREE, 1, 0, 1, 0, 0, 0, 0, 0));
        nRST = 1'b1;
        #1;
        checkIdle("abort release");
        @(negedge CLK);
        #1;
        checkIdle("abort settled");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache. Owns the single RAM port.
- Arbitrates icache fill reads (iREN) against dcache reads/writes (dREN/dWEN) and sequences each transaction against RAM handshake status.
- Returns per-side wait/load to the caches.
- Data side has fixed priority over instruction side; optional starvation guard.

Parameters:
- ADDR_W, 32, address width of iaddr/daddr/ramaddr
- DATA_W, 32, word width of all data buses
- STARVE_LIMIT, 4, consecutive data grants allowed while iREN pending (used only with optional feature)

Ports:
- CLK  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  icache fill read request
- iaddr  input  ADDR_W  icache fill address
- iwait  output  1  low for exactly the completing cycle of an instruction read
- iload  output  DATA_W  instruction word, valid when iwait low
- dREN  input  1  dcache read request
- dWEN  input  1  dcache write request; never asserted together with dREN
- daddr  input  ADDR_W  dcache address
- dstore  input  DATA_W  dcache write data
- dwait  output  1  low for exactly the completing cycle of a data access
- dload  output  DATA_W  data read word, valid when dwait low
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  ADDR_W  RAM address
- ramstore  output  DATA_W  RAM write data
- ramload  input  DATA_W  RAM read data
- ramstate  input  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR

Behaviour:
- Clock, reset: one clock CLK; asynchronous active-low reset nRST. Reset forces state IDLE and starvation counter 0.
- Outputs while in reset: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- States: IDLE, DGRANT, IGRANT (registered).
- IDLE:
  - No RAM enables; both waits 1.
  - If dREN|dWEN -> DGRANT; else if iREN -> IGRANT; else stay.
  - Arbitration costs exactly one cycle.
- DGRANT:
  - Drive ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - If ramstate==ACCESS: dwait=0 combinationally, dload=ramload; next state IDLE.
- IGRANT:
  - Drive ramREN=1, ramaddr=iaddr, ramWEN=0.
  - If ramstate==ACCESS: iwait=0, iload=ramload; next state IDLE.
- Wait signals:
  - iwait, dwait are combinational from state and ramstate; never low outside the owning grant state.
  - The side not granted sees wait=1 and load=0.
- Timing: minimum request-to-completion is 2 cycles (request seen in IDLE, ACCESS in first grant cycle). After any completion the arbiter spends one cycle in IDLE before the next grant (bus turnaround).
- ramstate handling: FREE or BUSY in a grant state -> hold state and outputs unchanged. ERROR -> hold and retry, no wait deassertion.
- Request withdrawn mid-grant (owner's enable drops before ACCESS): next state IDLE, RAM enables drop the same cycle, no wait pulse.
- Request changes mid-grant: address/data are passed through, not latched. The caches must hold them stable while wait=1.
- Simultaneous requests in IDLE: data wins (unless optional feature overrides).
- Reset mid-transaction: abort immediately to IDLE; RAM enables drop asynchronously.
- iload/dload are zero whenever their wait is 1.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- With macro:
  - A 3-bit-or-wider counter increments on each DGRANT->IDLE completion while iREN=1.
  - It clears on any IGRANT completion or when iREN=0 in IDLE.
  - When counter==STARVE_LIMIT and iREN=1 in IDLE, IGRANT is chosen even if the data side requests.
- Without macro: no counter logic; pure data-priority arbitration; STARVE_LIMIT unused.

Test Plan:
- Reset with iREN=1, dREN=1 asserted -> iwait=dwait=1, ramREN=ramWEN=0 throughout reset; IDLE after release.
- iREN=1, iaddr=0x0000_0040, RAM returns ACCESS on first grant cycle with ramload=0x2108_0001 -> iwait low in cycle 2 only, iload=0x2108_0001, dwait stays 1.
- iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEAD_BEEF) together, RAM BUSY 2 cycles then ACCESS -> ramWEN with 0x100/0xDEAD_BEEF first, dwait low at cycle 4; one IDLE cycle; then IGRANT.
- DGRANT with ramstate=ERROR 3 cycles then ACCESS -> dwait held 1 during ERROR, single low pulse on ACCESS.
- iREN drops in IGRANT before ACCESS -> ramREN=0 same cycle, no iwait pulse, state IDLE next cycle.
- ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, dREN and iREN held continuously -> grant order D,D,D,D,I,D...; without the macro, I is never granted.
